// File: rtl/inject_buffer_pkg.sv
// Shared types and sizing helpers for the injection flit buffer.
package inject_buffer_pkg;

    typedef enum logic [1:0] {
        INJ_HEADER  = 2'd0,
        INJ_SIZE    = 2'd1,
        INJ_PAYLOAD = 2'd2
    } inj_state_t;

    localparam int INJ_CNT_W = 32;

    // Occupancy needs one extra bit so that "full" is distinguishable from "empty".
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inject_buffer_flit_fifo.sv
// Flit storage for inject_buffer: circular buffer with occupancy counter.
// Pushes at full and pops at empty are ignored; data_o is read straight from storage.
module flit_fifo
    import inject_buffer_pkg::*;
#(
    parameter int FLIT_SIZE = 32,
    parameter int DEPTH     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [FLIT_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     count;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (count == OCC_W'(DEPTH));
    assign empty_o = (count == '0);
    assign data_o  = mem[rd_ptr];

    // Storage is deliberately not reset: contents are meaningless until pushed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + OCC_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - OCC_W'(1);
            end
        end
    end

endmodule

// File: rtl/inject_buffer.sv
// Injection flit buffer: decouples the source parser from NoC back-pressure and
// tracks packet framing (header, size, payload) on the output side.
module inject_buffer
    import inject_buffer_pkg::*;
#(
    parameter int FLIT_SIZE = 32,
    parameter int DEPTH     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 sop_o,
    output logic                 eop_o,
    output logic [INJ_CNT_W-1:0] pkt_cnt_o,
    output logic [INJ_CNT_W-1:0] flit_cnt_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    // Handshake: a flit moves on a side exactly in the cycle where valid (rx_i / tx_o)
    // and credit (credit_o / credit_i) are both high at the rising edge.

    inj_state_t           state;
    inj_state_t           state_next;
    logic [FLIT_SIZE-1:0] remaining;
    logic [FLIT_SIZE-1:0] remaining_next;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 pkt_done;

    flit_fifo #(
        .FLIT_SIZE (FLIT_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_i),
        .pop_i   (pop),
        .data_i  (data_i),
        .data_o  (data_o),
        .full_o  (full),
        .empty_o (empty)
    );

    assign credit_o = !full;
    assign tx_o     = !empty;
    assign pop      = tx_o && credit_i;
    assign state_o  = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= INJ_HEADER;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        case (state)
            INJ_HEADER: begin
                if (pop) begin
                    state_next = INJ_SIZE;
                end
            end
            INJ_SIZE: begin
                if (pop) begin
                    if (data_o == '0) begin
                        state_next = INJ_HEADER;
                    end else begin
                        remaining_next = data_o;
                        state_next     = INJ_PAYLOAD;
                    end
                end
            end
            INJ_PAYLOAD: begin
                if (pop) begin
                    remaining_next = remaining - FLIT_SIZE'(1);
                    if (remaining == FLIT_SIZE'(1)) begin
                        state_next = INJ_HEADER;
                    end
                end
            end
            default: begin
                state_next = INJ_HEADER;
            end
        endcase
    end

    // Framing flags describe the flit currently on data_o, so they only mean anything with tx_o.
    always_comb begin
        sop_o    = tx_o && (state == INJ_HEADER);
        eop_o    = tx_o && (((state == INJ_SIZE) && (data_o == '0)) ||
                            ((state == INJ_PAYLOAD) && (remaining == FLIT_SIZE'(1))));
        pkt_done = pop && eop_o;
        busy_o   = !empty || (state != INJ_HEADER);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_cnt_o  <= '0;
            flit_cnt_o <= '0;
        end else begin
            if (pop) begin
                flit_cnt_o <= flit_cnt_o + INJ_CNT_W'(1);
            end
            if (pkt_done) begin
                pkt_cnt_o <= pkt_cnt_o + INJ_CNT_W'(1);
            end
        end
    end

endmodule
